// File: rtl/reg_arbiter_pkg.sv
// Shared types and sizing for the two-requester register arbiter.
package reg_arbiter_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    // Arbiter FSM states; each grant state lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

endpackage : reg_arbiter_pkg

// File: rtl/reg_arbiter_dff_en.sv
// N-bit edge-triggered register with load enable and async active-low clear.
module dff_en #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Load d when enabled, otherwise hold; clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : dff_en

// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting two requesters write access to one shared
// register. Optional even-parity output Qpar under REG_ARBITER_PARITY_EN.
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] Q,
    output logic              Qsrc,
    output logic              Qvalid
`ifdef REG_ARBITER_PARITY_EN
    ,
    output logic              Qpar
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic              wr_en_c;
    logic [DATA_W-1:0] wr_data_c;
    logic              wr_src_c;

    // State register plus registered grants, source index and write strobe.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            Qsrc   <= 1'b0;
            Qvalid <= 1'b0;
            last   <= 1'b1;
        end else begin
            state  <= state_nxt;
            gnt0   <= (state_nxt == GNT0);
            gnt1   <= (state_nxt == GNT1);
            Qvalid <= wr_en_c;
            if (wr_en_c) begin
                Qsrc <= wr_src_c;
                last <= wr_src_c;
            end
        end
    end

    // Next state and write selection; the current grantee is never eligible.
    always_comb begin
        state_nxt = IDLE;
        wr_en_c   = 1'b0;
        wr_data_c = '0;
        wr_src_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                wr_en_c   = 1'b1;
                wr_data_c = data0;
                wr_src_c  = 1'b0;
                if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT1: begin
                wr_en_c   = 1'b1;
                wr_data_c = data1;
                wr_src_c  = 1'b1;
                if (req0) begin
                    state_nxt = GNT0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shared register storage.
    dff_en #(
        .N (DATA_W)
    ) u_q_reg (
        .clk   (Clk),
        .rst_n (Resetn),
        .en    (wr_en_c),
        .d     (wr_data_c),
        .q     (Q)
    );

`ifdef REG_ARBITER_PARITY_EN
    // Parity of the value being written, captured alongside Q.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Qpar <= 1'b0;
        end else if (wr_en_c) begin
            Qpar <= ^wr_data_c;
        end
    end
`endif

endmodule : reg_arbiter
